// File: rtl/square_decode.sv
// Square-wave decoder: measures alternating +/-volume runs, locks onto a stable
// half period and flags runs that break the pattern or never end.
module square_decode #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 21,
  parameter int TOLERANCE   = 0,
  parameter int MAX_RUN     = 2**21 - 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [DATA_WIDTH-1:0]  square_wave_i,
  output logic [COUNT_WIDTH-1:0] half_period_o,
  output logic [DATA_WIDTH-1:0]  volume_o,
  output logic                   locked_o,
  output logic                   valid_o,
  output logic                   error_o
);

  typedef enum logic [2:0] {IDLE, SYNC, RUN1, RUN2, LOCKED} state_e;

  localparam logic [COUNT_WIDTH-1:0] ONE_CNT    = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] MAX_CNT    = COUNT_WIDTH'(MAX_RUN);
  localparam logic [COUNT_WIDTH-1:0] MAX_CNT_M1 = COUNT_WIDTH'(MAX_RUN - 1);
  localparam logic [COUNT_WIDTH-1:0] TOL_CNT    = COUNT_WIDTH'(TOLERANCE);
  localparam logic [DATA_WIDTH-1:0]  MIN_LVL    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  prev_sample_q;
  logic [COUNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic [COUNT_WIDTH-1:0] len_a_q, len_a_d;
  logic [DATA_WIDTH-1:0]  lvl_a_q, lvl_a_d;
  logic [COUNT_WIDTH-1:0] half_period_q, half_period_d;
  logic [DATA_WIDTH-1:0]  volume_q, volume_d;
  logic                   locked_q, locked_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;

  logic                   edge_det;
  logic                   timeout;
  logic                   pair_match;
  logic                   run_accept;
  logic [DATA_WIDTH-1:0]  lvl_a_neg;
  logic [DATA_WIDTH-1:0]  vol_neg;
  logic [COUNT_WIDTH-1:0] run_diff;

  always_comb begin
    edge_det  = (square_wave_i != prev_sample_q);
    lvl_a_neg = -lvl_a_q;
    vol_neg   = -volume_q;
    run_diff  = (run_cnt_q >= half_period_q) ? (run_cnt_q - half_period_q)
                                             : (half_period_q - run_cnt_q);
    if (edge_det)
      run_cnt_d = ONE_CNT;
    else if (run_cnt_q == MAX_CNT)
      run_cnt_d = run_cnt_q;
    else
      run_cnt_d = run_cnt_q + ONE_CNT;
    // Fires only on the clock where the counter first reaches saturation.
    timeout    = !edge_det && (run_cnt_q == MAX_CNT_M1);
    pair_match = (run_cnt_q == len_a_q) && (prev_sample_q == lvl_a_neg) &&
                 (lvl_a_q != '0) && (lvl_a_q != MIN_LVL);
    run_accept = (run_diff <= TOL_CNT) && (prev_sample_q == lvl_a_neg) &&
                 ((prev_sample_q == volume_q) || (prev_sample_q == vol_neg));
  end

  always_comb begin
    state_d       = state_q;
    len_a_d       = len_a_q;
    lvl_a_d       = lvl_a_q;
    half_period_d = half_period_q;
    volume_d      = volume_q;
    locked_d      = locked_q;
    valid_d       = 1'b0;
    error_d       = 1'b0;
    if (!enable_i) begin
      state_d  = IDLE;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC: if (edge_det) state_d = RUN1;
        RUN1: begin
          if (edge_det) begin
            len_a_d = run_cnt_q;
            lvl_a_d = prev_sample_q;
            state_d = RUN2;
          end else if (timeout) begin
            error_d = 1'b1;
            state_d = SYNC;
          end
        end
        RUN2: begin
          if (edge_det) begin
            // lvl_a always tracks the level of the run just finished.
            len_a_d = run_cnt_q;
            lvl_a_d = prev_sample_q;
            if (pair_match) begin
              state_d       = LOCKED;
              half_period_d = len_a_q;
              volume_d      = lvl_a_q[DATA_WIDTH-1] ? lvl_a_neg : lvl_a_q;
              locked_d      = 1'b1;
              valid_d       = 1'b1;
            end
          end else if (timeout) begin
            error_d = 1'b1;
            state_d = SYNC;
          end
        end
        LOCKED: begin
          if (edge_det) begin
            len_a_d = run_cnt_q;
            lvl_a_d = prev_sample_q;
            if (run_accept) begin
              valid_d = 1'b1;
            end else begin
              error_d  = 1'b1;
              locked_d = 1'b0;
              state_d  = RUN2;
            end
          end else if (timeout) begin
            error_d  = 1'b1;
            locked_d = 1'b0;
            state_d  = SYNC;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      prev_sample_q <= '0;
      run_cnt_q     <= '0;
      len_a_q       <= '0;
      lvl_a_q       <= '0;
      half_period_q <= '0;
      volume_q      <= '0;
      locked_q      <= 1'b0;
      valid_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_sample_q <= square_wave_i;
      run_cnt_q     <= run_cnt_d;
      len_a_q       <= len_a_d;
      lvl_a_q       <= lvl_a_d;
      half_period_q <= half_period_d;
      volume_q      <= volume_d;
      locked_q      <= locked_d;
      valid_q       <= valid_d;
      error_q       <= error_d;
    end
  end

  assign half_period_o = half_period_q;
  assign volume_o      = volume_q;
  assign locked_o      = locked_q;
  assign valid_o       = valid_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_square_decode.sv
// Directed bench for square_decode: two instances share the input stream,
// dut0 with TOLERANCE=0 and dut1 with TOLERANCE=1, both with MAX_RUN=64.
module tb_square_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] sw;
  logic [20:0] hp0, hp1;
  logic [15:0] vol0, vol1;
  logic        locked0, locked1, valid0, valid1, error0, error1;

  int tests = 0;
  int fails = 0;
  int v_cnt0, e_cnt0, v_cnt1, e_cnt1;

  localparam logic [15:0] P  = 16'h00FF;
  localparam logic [15:0] N  = 16'hFF01;
  localparam logic [15:0] NA = 16'hFF00;

  always #5 clk = ~clk;

  square_decode #(.DATA_WIDTH(16), .COUNT_WIDTH(21), .TOLERANCE(0), .MAX_RUN(64)) dut0 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .square_wave_i(sw),
    .half_period_o(hp0), .volume_o(vol0), .locked_o(locked0),
    .valid_o(valid0), .error_o(error0)
  );

  square_decode #(.DATA_WIDTH(16), .COUNT_WIDTH(21), .TOLERANCE(1), .MAX_RUN(64)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .square_wave_i(sw),
    .half_period_o(hp1), .volume_o(vol1), .locked_o(locked1),
    .valid_o(valid1), .error_o(error1)
  );

  task automatic clr();
    v_cnt0 = 0; e_cnt0 = 0; v_cnt1 = 0; e_cnt1 = 0;
  endtask

  task automatic drive1(input logic [15:0] val);
    sw = val;
    @(posedge clk);
    #1;
    if (valid0) v_cnt0++;
    if (error0) e_cnt0++;
    if (valid1) v_cnt1++;
    if (error1) e_cnt1++;
  endtask

  task automatic run(input logic [15:0] val, input int n);
    for (int i = 0; i < n; i++) drive1(val);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; sw = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (locked0 !== 1'b0) begin fails++; $display("FAIL rst_locked: got %b want 0", locked0); end
    tests++; if (valid0 !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", valid0); end
    tests++; if (error0 !== 1'b0) begin fails++; $display("FAIL rst_error: got %b want 0", error0); end
    tests++; if (hp0 !== 21'd0) begin fails++; $display("FAIL rst_hp: got %0d want 0", hp0); end
    tests++; if (vol0 !== 16'h0) begin fails++; $display("FAIL rst_vol: got %h want 0000", vol0); end
    rst = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_lock();
    enable = 1'b1;
    clr();
    run(16'h0000, 3);
    run(P, 10);
    run(N, 10);
    tests++; if (locked0 !== 1'b0) begin fails++; $display("FAIL lock_early: got %b want 0", locked0); end
    tests++; if (v_cnt0 !== 0) begin fails++; $display("FAIL lock_early_valid: got %0d want 0", v_cnt0); end
    drive1(P);
    tests++; if (valid0 !== 1'b1) begin fails++; $display("FAIL lock_valid: got %b want 1", valid0); end
    tests++; if (locked0 !== 1'b1) begin fails++; $display("FAIL lock_locked: got %b want 1", locked0); end
    tests++; if (hp0 !== 21'd10) begin fails++; $display("FAIL lock_hp: got %0d want 10", hp0); end
    tests++; if (vol0 !== 16'h00FF) begin fails++; $display("FAIL lock_vol: got %h want 00ff", vol0); end
    tests++; if (error0 !== 1'b0) begin fails++; $display("FAIL lock_error: got %b want 0", error0); end
    tests++; if (locked1 !== 1'b1) begin fails++; $display("FAIL lock_locked1: got %b want 1", locked1); end
    clr();
    run(P, 9);
    tests++; if (v_cnt0 !== 0) begin fails++; $display("FAIL lock_pulse_width: got %0d want 0", v_cnt0); end
    drive1(N);
    tests++; if (valid0 !== 1'b1) begin fails++; $display("FAIL lock_valid2: got %b want 1", valid0); end
    run(N, 9);
    drive1(P);
    tests++; if (valid0 !== 1'b1) begin fails++; $display("FAIL lock_valid3: got %b want 1", valid0); end
    tests++; if (locked0 !== 1'b1) begin fails++; $display("FAIL lock_hold: got %b want 1", locked0); end
    $display("[TB] test_lock done");
  endtask

  task automatic test_mismatch();
    run(P, 6);
    drive1(N);
    tests++; if (error0 !== 1'b1) begin fails++; $display("FAIL mis_error: got %b want 1", error0); end
    tests++; if (locked0 !== 1'b0) begin fails++; $display("FAIL mis_locked: got %b want 0", locked0); end
    tests++; if (valid0 !== 1'b0) begin fails++; $display("FAIL mis_valid: got %b want 0", valid0); end
    tests++; if (hp0 !== 21'd10) begin fails++; $display("FAIL mis_hp: got %0d want 10", hp0); end
    run(N, 9);
    drive1(P);
    tests++; if (locked0 !== 1'b0) begin fails++; $display("FAIL mis_relock_early: got %b want 0", locked0); end
    tests++; if (error0 !== 1'b0) begin fails++; $display("FAIL mis_error_clear: got %b want 0", error0); end
    run(P, 9);
    drive1(N);
    tests++; if (locked0 !== 1'b1) begin fails++; $display("FAIL mis_relock: got %b want 1", locked0); end
    tests++; if (valid0 !== 1'b1) begin fails++; $display("FAIL mis_relock_valid: got %b want 1", valid0); end
    $display("[TB] test_mismatch done");
  endtask

  task automatic test_tolerance();
    run(N, 10);
    drive1(P);
    tests++; if (valid1 !== 1'b1) begin fails++; $display("FAIL tol1_valid11: got %b want 1", valid1); end
    tests++; if (error1 !== 1'b0) begin fails++; $display("FAIL tol1_error11: got %b want 0", error1); end
    tests++; if (locked1 !== 1'b1) begin fails++; $display("FAIL tol1_locked11: got %b want 1", locked1); end
    tests++; if (error0 !== 1'b1) begin fails++; $display("FAIL tol0_error11: got %b want 1", error0); end
    run(P, 11);
    drive1(N);
    tests++; if (error1 !== 1'b1) begin fails++; $display("FAIL tol1_error12: got %b want 1", error1); end
    tests++; if (locked1 !== 1'b0) begin fails++; $display("FAIL tol1_locked12: got %b want 0", locked1); end
    tests++; if (valid1 !== 1'b0) begin fails++; $display("FAIL tol1_valid12: got %b want 0", valid1); end
    run(N, 9);
    drive1(P);
    run(P, 9);
    drive1(N);
    tests++; if (locked0 !== 1'b1) begin fails++; $display("FAIL tol_relock0: got %b want 1", locked0); end
    tests++; if (locked1 !== 1'b1) begin fails++; $display("FAIL tol_relock1: got %b want 1", locked1); end
    $display("[TB] test_tolerance done");
  endtask

  task automatic test_reset_mid_run2();
    run(N, 6);
    drive1(P);
    run(P, 4);
    #2;
    rst = 1'b1;
    #1;
    tests++; if (hp0 !== 21'd0) begin fails++; $display("FAIL arst_hp: got %0d want 0", hp0); end
    tests++; if (vol0 !== 16'h0) begin fails++; $display("FAIL arst_vol: got %h want 0000", vol0); end
    tests++; if (locked0 !== 1'b0) begin fails++; $display("FAIL arst_locked: got %b want 0", locked0); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    run(16'h0000, 3);
    run(P, 10);
    run(N, 10);
    tests++; if (locked0 !== 1'b0) begin fails++; $display("FAIL arst_early: got %b want 0", locked0); end
    drive1(P);
    tests++; if (locked0 !== 1'b1) begin fails++; $display("FAIL arst_relock: got %b want 1", locked0); end
    tests++; if (hp0 !== 21'd10) begin fails++; $display("FAIL arst_relock_hp: got %0d want 10", hp0); end
    tests++; if (v_cnt0 !== 1) begin fails++; $display("FAIL arst_valid_cnt: got %0d want 1", v_cnt0); end
    $display("[TB] test_reset_mid_run2 done");
  endtask

  task automatic test_timeout_disable();
    clr();
    run(P, 62);
    tests++; if (e_cnt0 !== 0) begin fails++; $display("FAIL to_early: got %0d want 0", e_cnt0); end
    drive1(P);
    tests++; if (error0 !== 1'b1) begin fails++; $display("FAIL to_error: got %b want 1", error0); end
    tests++; if (locked0 !== 1'b0) begin fails++; $display("FAIL to_locked: got %b want 0", locked0); end
    tests++; if (valid0 !== 1'b0) begin fails++; $display("FAIL to_valid: got %b want 0", valid0); end
    tests++; if (error1 !== 1'b1) begin fails++; $display("FAIL to_error1: got %b want 1", error1); end
    drive1(P);
    tests++; if (error0 !== 1'b0) begin fails++; $display("FAIL to_single_pulse: got %b want 0", error0); end
    tests++; if (hp0 !== 21'd10) begin fails++; $display("FAIL to_hp: got %0d want 10", hp0); end
    enable = 1'b0;
    drive1(N);
    tests++; if (locked0 !== 1'b0) begin fails++; $display("FAIL dis_locked: got %b want 0", locked0); end
    tests++; if (hp0 !== 21'd10) begin fails++; $display("FAIL dis_hp: got %0d want 10", hp0); end
    enable = 1'b1;
    drive1(N);
    run(P, 10);
    run(N, 10);
    drive1(P);
    tests++; if (locked0 !== 1'b1) begin fails++; $display("FAIL dis_prelock: got %b want 1", locked0); end
    enable = 1'b0;
    drive1(P);
    tests++; if (locked0 !== 1'b0) begin fails++; $display("FAIL dis_unlock: got %b want 0", locked0); end
    tests++; if (vol0 !== 16'h00FF) begin fails++; $display("FAIL dis_vol: got %h want 00ff", vol0); end
    clr();
    run(P, 8);
    drive1(N);
    tests++; if (v_cnt0 !== 0) begin fails++; $display("FAIL dis_valid_cnt: got %0d want 0", v_cnt0); end
    tests++; if (e_cnt0 !== 0) begin fails++; $display("FAIL dis_error_cnt: got %0d want 0", e_cnt0); end
    $display("[TB] test_timeout_disable done");
  endtask

  task automatic test_asymmetric();
    enable = 1'b1;
    clr();
    for (int k = 0; k < 4; k++) begin
      run(P, 10);
      run(NA, 10);
    end
    drive1(P);
    tests++; if (v_cnt0 !== 0) begin fails++; $display("FAIL asym_valid: got %0d want 0", v_cnt0); end
    tests++; if (v_cnt1 !== 0) begin fails++; $display("FAIL asym_valid1: got %0d want 0", v_cnt1); end
    tests++; if (locked0 !== 1'b0) begin fails++; $display("FAIL asym_locked: got %b want 0", locked0); end
    $display("[TB] test_asymmetric done");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_mismatch();
    test_tolerance();
    test_reset_mid_run2();
    test_timeout_disable();
    test_asymmetric();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
